// File: rtl/verif_store_mem_if.sv
// Core-side memory port of verif_store_mem: request/write channel and read response.
interface verif_store_mem_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic                  req_i;
    logic                  gnt_o;
    logic                  we_i;
    logic [63:0]           addr_i;
    logic [BYTES-1:0]      be_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport master (
        output req_i, we_i, addr_i, be_i, data_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, data_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/verif_store_mem.sv
// Pipelined behavioural memory: NOP-filled program image plus a circular byte store log
// whose newest matching entry overrides image bytes on reads.
module verif_store_mem #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned LOG_DEPTH    = 32,
    parameter int unsigned INSTR_WORDS  = 128,
    parameter logic [63:0] BOOT_ADDR    = 64'h1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] NOP          = 32'h00000013,
    localparam int unsigned BYTES       = DATA_WIDTH / 8,
    localparam int unsigned IDX_W       = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1,
    localparam int unsigned CNT_W       = $clog2(LOG_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    verif_store_mem_if.slave     mem,
    input  logic                 prog_we_i,
    input  logic [IDX_W-1:0]     prog_idx_i,
    input  logic [31:0]          prog_data_i,
    output logic [CNT_W-1:0]     log_count_o,
    output logic                 log_wrap_o
);
    localparam int unsigned PTR_W = $clog2(LOG_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   cnt_ext_t;

    logic [31:0]           img [INSTR_WORDS] = '{default: NOP};
    logic [63:0]           log_addr [LOG_DEPTH];
    logic [7:0]            log_data [LOG_DEPTH];
    ptr_t                  wptr;
    cnt_t                  log_cnt;
    logic                  wrap_q;

    logic                  rd_acc;
    logic                  wr_acc;
    logic [63:0]           base_addr;
    logic [DATA_WIDTH-1:0] rd_merged;
    ptr_t                  wslot [BYTES];
    cnt_ext_t              n_app;

    logic [READ_LATENCY-1:0] rv_pipe;
    logic [DATA_WIDTH-1:0]   rd_pipe [READ_LATENCY];

    assign mem.gnt_o   = mem.req_i & rst_ni;
    assign rd_acc      = mem.gnt_o & ~mem.we_i;
    assign wr_acc      = mem.gnt_o & mem.we_i;
    assign base_addr   = mem.addr_i & ~64'(BYTES - 1);
    assign log_count_o = log_cnt;
    assign log_wrap_o  = wrap_q;

    always_ff @(posedge clk_i) begin
        if (prog_we_i) begin
            img[prog_idx_i] <= prog_data_i;
        end
    end

    always_comb begin
        logic [63:0] baddr;
        logic [63:0] boff;
        logic [31:0] word;
        cnt_ext_t    age;
        ptr_t        slot;
        baddr     = '0;
        boff      = '0;
        word      = NOP;
        age       = '0;
        slot      = '0;
        rd_merged = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            baddr = base_addr + 64'(b);
            boff  = baddr - BOOT_ADDR;
            word  = NOP;
            if (enable_i && (baddr >= BOOT_ADDR) && ((boff >> 2) < 64'(INSTR_WORDS))) begin
                word = img[boff[IDX_W+1:2]];
            end
            rd_merged[8*b +: 8] = word[8*baddr[1:0] +: 8];
            // Oldest-to-newest by age behind wptr, so the newest hit is assigned last.
            for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
                age  = cnt_ext_t'(LOG_DEPTH - i);
                slot = wptr - ptr_t'(LOG_DEPTH - i);
                if ((age <= cnt_ext_t'(log_cnt)) && (log_addr[slot] == baddr)) begin
                    rd_merged[8*b +: 8] = log_data[slot];
                end
            end
        end
    end

    always_comb begin
        cnt_ext_t n;
        n = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            wslot[b] = wptr + ptr_t'(n);
            if (wr_acc && mem.be_i[b]) begin
                n = n + cnt_ext_t'(1);
            end
        end
        n_app = n;
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (wr_acc && mem.be_i[b]) begin
                log_addr[wslot[b]] <= base_addr + 64'(b);
                log_data[wslot[b]] <= mem.data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            log_cnt <= '0;
            wrap_q  <= 1'b0;
        end else if (n_app != '0) begin
            wptr <= wptr + ptr_t'(n_app);
            if ((cnt_ext_t'(log_cnt) + n_app) > cnt_ext_t'(LOG_DEPTH)) begin
                log_cnt <= cnt_t'(LOG_DEPTH);
                wrap_q  <= 1'b1;
            end else begin
                log_cnt <= cnt_t'(cnt_ext_t'(log_cnt) + n_app);
            end
        end
    end

    // Data stages only load on a valid beat, so the last stage holds the previous response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rv_pipe <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= {(DATA_WIDTH / 32){NOP}};
            end
        end else begin
            rv_pipe[0] <= rd_acc;
            if (rd_acc) begin
                rd_pipe[0] <= rd_merged;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                rv_pipe[i] <= rv_pipe[i-1];
                if (rv_pipe[i-1]) begin
                    rd_pipe[i] <= rd_pipe[i-1];
                end
            end
        end
    end

    assign mem.rvalid_o = rv_pipe[READ_LATENCY-1];
    assign mem.rdata_o  = rd_pipe[READ_LATENCY-1];
endmodule

// File: tb/tb_verif_store_mem.sv
// Randomised and directed bench for verif_store_mem against a queue-based reference model.
module tb_verif_store_mem;
    localparam int unsigned DW   = 64;
    localparam int unsigned BY   = DW / 8;
    localparam int unsigned LD   = 32;
    localparam int unsigned IW   = 128;
    localparam int unsigned RL   = 3;
    localparam logic [63:0] BOOT = 64'h1000;
    localparam logic [31:0] NOPW = 32'h00000013;
    localparam logic [63:0] NOP2 = {NOPW, NOPW};

    logic        clk_i       = 1'b0;
    logic        rst_ni      = 1'b0;
    logic        enable_i    = 1'b1;
    logic        prog_we_i   = 1'b0;
    logic [6:0]  prog_idx_i  = '0;
    logic [31:0] prog_data_i = '0;
    logic [5:0]  log_count_o;
    logic        log_wrap_o;

    verif_store_mem_if #(.DATA_WIDTH(DW)) bus ();

    verif_store_mem #(
        .DATA_WIDTH(DW), .LOG_DEPTH(LD), .INSTR_WORDS(IW),
        .BOOT_ADDR(BOOT), .READ_LATENCY(RL), .NOP(NOPW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .mem(bus),
        .prog_we_i(prog_we_i), .prog_idx_i(prog_idx_i), .prog_data_i(prog_data_i),
        .log_count_o(log_count_o), .log_wrap_o(log_wrap_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] m_img [IW];
    logic [63:0] q_addr [$];
    logic [7:0]  q_data [$];
    logic        m_wrap   = 1'b0;
    logic [63:0] exp_data [$];
    int          exp_due [$];
    logic [63:0] m_rdata  = NOP2;
    logic [63:0] bases [6] = '{64'h0FF8, 64'h1000, 64'h1008, 64'h11F0, 64'h11F8, 64'h2000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [63:0] addr);
        logic [63:0] base, ba, r;
        logic [31:0] w;
        bit          hit;
        base = addr - (addr % BY);
        r    = '0;
        for (int b = 0; b < BY; b++) begin
            ba  = base + 64'(b);
            hit = 0;
            for (int i = q_addr.size() - 1; i >= 0; i--) begin
                if (!hit && q_addr[i] == ba) begin
                    r[8*b +: 8] = q_data[i];
                    hit = 1;
                end
            end
            if (!hit) begin
                w = NOPW;
                if (enable_i && ba >= BOOT && (ba - BOOT) / 4 < IW) w = m_img[(ba - BOOT) / 4];
                r[8*b +: 8] = w[8*(ba % 4) +: 8];
            end
        end
        return r;
    endfunction

    task automatic step(input logic req, input logic we, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] data);
        bus.req_i  = req;
        bus.we_i   = we;
        bus.addr_i = addr;
        bus.be_i   = be;
        bus.data_i = data;
        @(posedge clk_i);
        cyc++;
        if (rst_ni && req && !we) begin
            exp_data.push_back(model_read(addr));
            exp_due.push_back(cyc + RL - 1);
        end
        if (rst_ni && req && we) begin
            for (int b = 0; b < BY; b++) begin
                if (be[b]) begin
                    q_addr.push_back(addr - (addr % BY) + 64'(b));
                    q_data.push_back(data[8*b +: 8]);
                    if (q_addr.size() > LD) begin
                        void'(q_addr.pop_front());
                        void'(q_data.pop_front());
                        m_wrap = 1'b1;
                    end
                end
            end
        end
        if (prog_we_i) m_img[prog_idx_i] = prog_data_i;
        #2;
        prog_we_i = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic prog(input logic [6:0] idx, input logic [31:0] data);
        prog_we_i   = 1'b1;
        prog_idx_i  = idx;
        prog_data_i = data;
        idle();
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0;
        exp_data.delete();
        exp_due.delete();
        q_addr.delete();
        q_data.delete();
        m_wrap  = 1'b0;
        m_rdata = NOP2;
        repeat (n) idle();
        rst_ni = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [63:0] addr, input logic [63:0] exp);
        step(1'b1, 1'b0, addr, '0, '0);
        repeat (RL - 1) idle();
        check({tag, "_valid"}, 64'(bus.rvalid_o), 64'd1);
        check(tag, bus.rdata_o, exp);
    endtask

    always @(negedge clk_i) begin
        logic exp_v;
        exp_v = (exp_due.size() != 0) && (exp_due[0] == cyc);
        check("rvalid", 64'(bus.rvalid_o), 64'(exp_v));
        if (exp_v) begin
            m_rdata = exp_data.pop_front();
            void'(exp_due.pop_front());
        end
        check("rdata", bus.rdata_o, m_rdata);
        check("log_count", 64'(log_count_o), 64'(q_addr.size()));
        check("log_wrap", 64'(log_wrap_o), 64'(m_wrap));
        check("gnt", 64'(bus.gnt_o), 64'(bus.req_i & rst_ni));
    end

    initial begin
        int unsigned r;
        logic [63:0] a;
        foreach (m_img[i]) m_img[i] = NOPW;
        do_reset(3);

        prog(7'd0, 32'hDEADBEEF);
        prog(7'd1, 32'h00100093);
        prog(7'd2, 32'h12345678);
        read_check("prog_read", 64'h1000, 64'h00100093_DEADBEEF);

        step(1'b1, 1'b0, 64'h1000, '0, '0);
        step(1'b1, 1'b0, 64'h1008, '0, '0);
        do_reset(3);
        check("rst_rdata", bus.rdata_o, NOP2);
        check("rst_count", 64'(log_count_o), 64'd0);
        repeat (6) idle();

        step(1'b1, 1'b1, 64'h1000, 8'h05, 64'h00000000_00330011);
        read_check("merge_read", 64'h1000, 64'h00100093_DE33BE11);
        check("merge_count", 64'(log_count_o), 64'd2);
        enable_i = 1'b0;
        read_check("disabled_read", 64'h1000, 64'h00000013_00330011);
        enable_i = 1'b1;
        read_check("below_boot", 64'h0, NOP2);

        step(1'b1, 1'b0, 64'h1008, '0, '0);
        step(1'b1, 1'b0, 64'h1003, '0, '0);
        step(1'b1, 1'b0, 64'h0FF8, '0, '0);
        check("lat_first", bus.rdata_o, 64'h00000013_12345678);
        idle();
        check("lat_second", bus.rdata_o, 64'h00100093_DE33BE11);
        idle();
        check("lat_third", bus.rdata_o, NOP2);
        idle();

        for (int i = 0; i <= 32; i++) step(1'b1, 1'b1, 64'h2000, 8'h01, 64'(i));
        check("wrap_count", 64'(log_count_o), 64'd32);
        check("wrap_flag", 64'(log_wrap_o), 64'd1);
        read_check("newest_wins", 64'h2000, 64'h00000013_00000020);
        read_check("image_end", 64'h11FC, 64'h00000013_00000013);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            a = bases[$urandom_range(0, 5)] + 64'($urandom_range(0, 15));
            enable_i = ($urandom_range(0, 9) != 0);
            if (r < 2) begin
                do_reset(2);
            end else begin
                if (r < 14) begin
                    prog_we_i   = 1'b1;
                    prog_idx_i  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 7))
                                                             : 7'($urandom_range(124, 127));
                    prog_data_i = $urandom;
                end
                if (r < 55)      step(1'b1, 1'b0, a, '0, '0);
                else if (r < 85) step(1'b1, 1'b1, a, 8'($urandom), {$urandom, $urandom});
                else             idle();
            end
        end

        repeat (RL + 2) idle();
        check("drain", 64'(exp_due.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/verif_store_mem.md
# verif_store_mem

Parametrised, pipelined behavioural memory model for the CVA6 verification bench. It serves instruction fetches from a NOP-initialised, bench-loadable program image based at `BOOT_ADDR`. It records byte stores in a circular store log and merges logged bytes into read data per byte, newest write winning. It sits on the core-side memory port in place of the fixed-width model, adding configurable data width, log depth and read latency, per-byte merging, wrap detection and a program-load port.

## Interface
Parameters:
- `DATA_WIDTH`, 64: read/write data width; multiple of 32. `BYTES` = `DATA_WIDTH`/8.
- `LOG_DEPTH`, 32: store-log entries; power of two, at least `BYTES`.
- `INSTR_WORDS`, 128: 32-bit words in the program image.
- `BOOT_ADDR`, 64'h1000: byte address of program word 0.
- `READ_LATENCY`, 1: cycles from accepted read to `rvalid_o`; legal range 1..4.
- `NOP`, 32'h00000013: fill word.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  program image visible; when 0, image bytes read as `NOP`.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request accepted; equals `req_i & rst_ni`, combinational.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  64  byte address; aligned down to `BYTES`.
- `be_i`  in  `BYTES`  write byte enables.
- `data_i`  in  `DATA_WIDTH`  write data.
- `rvalid_o`  out  1  read data valid.
- `rdata_o`  out  `DATA_WIDTH`  read data; holds its last value while `rvalid_o`=0.
- `prog_we_i`  in  1  program-image word write.
- `prog_idx_i`  in  $clog2(`INSTR_WORDS`)  program word index.
- `prog_data_i`  in  32  program word.
- `log_count_o`  out  $clog2(`LOG_DEPTH`+1)  valid log entries.
- `log_wrap_o`  out  1  sticky; set when a valid log entry has been overwritten.

## Operation
- Program image: every word is `NOP` at time zero. Reset does not touch the image. `prog_we_i` writes `prog_data_i` to word `prog_idx_i` at the clock edge.
- Read (accepted request with `we_i`=0), base address `A` = `addr_i` with the low log2(`BYTES`) bits cleared. For each byte b of the result:
  - If any valid log entry has address `A`+b, the byte comes from the newest such entry.
  - Otherwise the byte comes from image word (`A`+b−`BOOT_ADDR`)>>2, at byte offset (`A`+b)%4.
  - If `enable_i`=0, or `A`+b < `BOOT_ADDR`, or the word index ≥ `INSTR_WORDS`, the byte comes from `NOP` instead.
  - There is no zero-fill: unlogged bytes always come from the image or `NOP`.
- Read data is computed in the accept cycle. It sees all log and image writes committed at earlier edges. It does not see a `prog_we_i` in the same cycle.
- Write (accepted request with `we_i`=1): each enabled byte is appended in ascending b order as entry {`A`+b, `data_i` byte b}.
  - Entries are written at `wptr`, then `wptr` increments modulo `LOG_DEPTH`. Up to `BYTES` entries are appended per cycle.
  - `log_count_o` saturates at `LOG_DEPTH`. When full, each append overwrites the oldest entry and sets `log_wrap_o`.
  - A write with `be_i`=0 changes nothing. Writes produce no response.
  - The program image is never modified by writes.
- Newest-entry priority is by age relative to `wptr`, not by array index, so it stays correct across wrap-around.

## Timing
- Reset (asynchronous, while `rst_ni`=0):
  - `rvalid_o`=0; `rdata_o` = `NOP` replicated; `log_count_o`=0; `log_wrap_o`=0; `wptr`=0.
  - All pipeline valid bits are cleared. Reads in flight are dropped and never return.
  - `gnt_o`=0.
- Read accepted in cycle n: `rvalid_o`=1 with data in cycle n+`READ_LATENCY`, for exactly one cycle.
- Back-to-back reads return in order, one per cycle. There is no backpressure.
- Writes update the log at the accept edge and are visible to a read accepted in the next cycle.

## Test plan
- Reset: hold `rst_ni`=0 mid-stream with 2 reads in flight (`READ_LATENCY`=3) -> `rvalid_o`=0 throughout, `rdata_o`=64'h00000013_00000013, `log_count_o`=0, and no late `rvalid_o` after release.
- Program read: load word 0=32'hDEADBEEF and word 1=32'h00100093, then read 0x1000 -> next cycle `rdata_o`=64'h00100093_DEADBEEF with `rvalid_o`=1.
- Byte merge: from the previous state, write 0x1000 with `be_i`=8'h05 and `data_i`=64'h00000000_00330011, then read 0x1000 -> 64'h00100093_DE33BE11, `log_count_o`=2.
- Wrap and newest-wins: write 33 single bytes (values 0..32) to 0x2000 -> `log_count_o`=32, `log_wrap_o`=1; read 0x2000 -> byte 0 = 8'h20, upper bytes = `NOP` bytes.
- Range/enable: read 0x0 -> `NOP` pair. With `enable_i`=0, read 0x1000 after the merge test -> 64'h00000013_00330011.
- Latency: `READ_LATENCY`=3, reads at cycles 5, 6, 7 -> `rvalid_o` at 8, 9, 10 with data in request order.
